// File: rtl/wash_cycle_controller_if.sv
// rtl/wash_cycle_controller_if.sv - wash controller user, timer and status signals
interface wash_cycle_controller_if #(
  parameter int MIN_W = 5
);
  logic             coin_in;
  logic             double_wash;
  logic             timer_pause;
  logic [MIN_W-1:0] timer_minutes;
  logic             timer_enable;
  logic             pause_flag;
  logic             wash_done;
  logic [2:0]       state_out;

  modport master (
    input  coin_in,
    input  double_wash,
    input  timer_pause,
    input  timer_minutes,
    output timer_enable,
    output pause_flag,
    output wash_done,
    output state_out
  );

  modport slave (
    output coin_in,
    output double_wash,
    output timer_pause,
    output timer_minutes,
    input  timer_enable,
    input  pause_flag,
    input  wash_done,
    input  state_out
  );
endinterface

// File: rtl/wash_cycle_controller.sv
// rtl/wash_cycle_controller.sv - wash cycle sequencing FSM driving the minute timer
module wash_cycle_controller #(
  parameter int FILL_MIN  = 2,
  parameter int WASH_MIN  = 5,
  parameter int RINSE_MIN = 2,
  parameter int SPIN_MIN  = 1,
  parameter int MIN_W     = 5
) (
  input  logic                   clk,
  input  logic                   rst_n,
  wash_cycle_controller_if.master bus
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_FILL  = 3'd1,
    S_WASH  = 3'd2,
    S_RINSE = 3'd3,
    S_SPIN  = 3'd4
  } state_t;

  localparam logic [MIN_W-1:0] FILL_LEN  = MIN_W'(FILL_MIN);
  localparam logic [MIN_W-1:0] WASH_LEN  = MIN_W'(WASH_MIN);
  localparam logic [MIN_W-1:0] RINSE_LEN = MIN_W'(RINSE_MIN);
  localparam logic [MIN_W-1:0] SPIN_LEN  = MIN_W'(SPIN_MIN);

  state_t           state;
  state_t           state_next;
  logic             dw_reg;
  logic             dw_next;
  logic             pass_cnt;
  logic             pass_next;
  logic             restart;
  logic             restart_next;
  logic             done_reg;
  logic             done_next;
  logic [MIN_W-1:0] phase_len;
  logic             phase_end;
  logic             enable;
  logic             paused;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= S_IDLE;
      dw_reg   <= 1'b0;
      pass_cnt <= 1'b0;
      restart  <= 1'b1;
      done_reg <= 1'b0;
    end else begin
      state    <= state_next;
      dw_reg   <= dw_next;
      pass_cnt <= pass_next;
      restart  <= restart_next;
      done_reg <= done_next;
    end
  end

  always_comb begin
    phase_len = '0;
    case (state)
      S_FILL:  phase_len = FILL_LEN;
      S_WASH:  phase_len = WASH_LEN;
      S_RINSE: phase_len = RINSE_LEN;
      S_SPIN:  phase_len = SPIN_LEN;
      default: phase_len = '0;
    endcase
  end

  // The first cycle of each phase holds the timer in clear so it restarts at 0.
  assign enable    = (state != S_IDLE) && !restart;
  assign paused    = (state == S_SPIN) && bus.timer_pause;
  // A pause in SPIN outranks a simultaneous phase end.
  assign phase_end = enable && (bus.timer_minutes == phase_len) && !paused;

  always_comb begin
    state_next = state;
    dw_next    = dw_reg;
    pass_next  = pass_cnt;
    done_next  = done_reg;
    case (state)
      S_IDLE: begin
        if (bus.coin_in) begin
          state_next = S_FILL;
          dw_next    = bus.double_wash;
          pass_next  = 1'b0;
          done_next  = 1'b0;
        end
      end
      S_FILL: begin
        if (phase_end) state_next = S_WASH;
      end
      S_WASH: begin
        if (phase_end) state_next = S_RINSE;
      end
      S_RINSE: begin
        if (phase_end) begin
          if (dw_reg && !pass_cnt) begin
            state_next = S_WASH;
            pass_next  = 1'b1;
          end else begin
            state_next = S_SPIN;
          end
        end
      end
      S_SPIN: begin
        if (phase_end) begin
          state_next = S_IDLE;
          done_next  = 1'b1;
        end
      end
      default: state_next = S_IDLE;
    endcase
    restart_next = (state_next != state);
  end

  assign bus.timer_enable = enable;
  assign bus.pause_flag   = paused;
  assign bus.wash_done    = done_reg;
  assign bus.state_out    = state;

endmodule

// File: doc/wash_cycle_controller.md
Name: wash_cycle_controller

Overview:
- Top-level sequencing FSM for the washing-machine controller unit; the consumer of the minute timer.
- Drives timer_enable and pause_flag into the minute timer and reads back timer_minutes.
- Steps through fill, wash, rinse and spin phases of programmed durations, with an optional second wash/rinse pass.
- Asserts wash_done when the cycle completes.

Parameters:
- FILL_MIN, 2, fill-water phase length in minutes
- WASH_MIN, 5, wash phase length in minutes
- RINSE_MIN, 2, rinse phase length in minutes
- SPIN_MIN, 1, spin phase length in minutes
- MIN_W, 5, width of the minute bus (max phase length 31)

Ports:
- clk  input  1  system clock, rising-edge active
- rst_n  input  1  asynchronous active-low reset
- coin_in  input  1  level; high in IDLE starts a cycle
- double_wash  input  1  selects two wash/rinse passes; sampled on IDLE exit
- timer_pause  input  1  user pause request; honoured only in SPIN
- timer_minutes  input  MIN_W  elapsed minutes in current phase, from the timer
- timer_enable  output  1  run/clear control to the timer; 0 clears the timer
- pause_flag  output  1  freeze request to the timer
- wash_done  output  1  cycle-complete indication
- state_out  output  3  current state encoding, for display/debug

Behaviour:
- Reset (async, rst_n low):
  - state = IDLE, dw_reg = 0, pass_cnt = 0, restart = 1.
  - All outputs 0; state_out = 0.
  - Reset mid-cycle aborts immediately; no resume.
- States and encodings: IDLE=0, FILL=1, WASH=2, RINSE=3, SPIN=4. Codes 5-7 are illegal and go to IDLE on the next edge.
- Registered state. Outputs are combinational from registered state/flags; no input-to-output path except pause_flag.
- Timer clearing:
  - restart flag is set on every state change and cleared the following cycle.
  - timer_enable = (state != IDLE) && !restart.
  - Hence timer_enable is low for exactly the first cycle of every phase, guaranteeing timer_minutes returns to 0 before counting.
- Phase completion: phase_end = timer_enable && (timer_minutes == phase length of current state). Comparison is equality on MIN_W bits; no overflow handling is needed.
- Transitions:
  - IDLE -> FILL when coin_in = 1. Same edge: dw_reg <= double_wash, pass_cnt <= 0, wash_done <= 0.
  - FILL -> WASH on phase_end.
  - WASH -> RINSE on phase_end.
  - RINSE -> WASH on phase_end if dw_reg = 1 and pass_cnt = 0; same edge sets pass_cnt <= 1.
  - RINSE -> SPIN otherwise on phase_end.
  - SPIN -> IDLE on phase_end and not paused; same edge sets wash_done <= 1.
- Pause:
  - pause_flag = (state == SPIN) && timer_pause; combinational.
  - While pause_flag is 1, phase_end is suppressed, state holds, and timer_enable stays 1 so the timer freezes rather than clears.
  - timer_pause in any other state is ignored: pause_flag = 0.
- coin_in and double_wash outside IDLE are ignored; changing double_wash mid-cycle has no effect.
- wash_done:
  - Set on SPIN -> IDLE; held high in IDLE.
  - Cleared on the edge that leaves IDLE (coin_in).
  - If coin_in is high at the completion edge, the FSM sits in IDLE one cycle with wash_done = 1, then restarts.
- Simultaneous events:
  - phase_end and timer_pause in the same SPIN cycle: pause wins.
  - Reset overrides everything.
- Cycle lengths at defaults:
  - Single: 2+5+2+1 = 10 minutes plus 4 clear cycles.
  - Double: 2+5+2+5+2+1 = 17 minutes plus 6 clear cycles.
- Implementation size: about 150-220 lines (FSM, restart flag, pass counter, duration mux).

Test Plan:
- Reset, then coin_in = 1 for 1 cycle -> state_out = 1. timer_enable = 0 on the first FILL cycle and 1 on the next. wash_done = 0.
- Single cycle, bench drives timer_minutes to match each phase (2, 5, 2, 1) -> state_out sequence 1,2,3,4,0. timer_enable low exactly one cycle after each change. wash_done = 1 in IDLE.
- double_wash = 1 at start, toggled to 0 mid-wash -> sequence 1,2,3,2,3,4,0. Second rinse exits to SPIN, not WASH.
- In SPIN, timer_pause = 1 while timer_minutes = 1 -> pause_flag = 1, state holds at 4, timer_enable = 1. Release -> IDLE next edge, wash_done = 1.
- timer_pause = 1 during WASH with timer_minutes = 5 -> pause_flag = 0; RINSE is entered normally.
- rst_n low for 1 cycle mid-RINSE (state 3) -> immediate IDLE, all outputs 0. A coin_in during WASH after restart is ignored (no state change).
